// File: rtl/bin2bcd_seq.sv
// ============================================================================
// bin2bcd_seq : parametrised sequential binary-to-BCD converter (double dabble)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3,
   parameter int SIGNED = 0
) (
   input  logic                  clk,
   input  logic                  clear_BAR,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  sign,
   output logic                  overflow
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [BIN_W-1:0]     r_opnd;
   logic [ACC_W-1:0]     r_acc;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_sign;
   logic                 r_ovf;

   logic                 w_neg;
   logic [BIN_W-1:0]     w_mag;
   logic [ACC_W-1:0]     w_adj;
   logic [ACC_W-1:0]     w_shift;
   logic                 w_ovf_next;
   logic                 w_last;

   assign w_neg = (SIGNED != 0) && bin_in[BIN_W-1];
   assign w_mag = w_neg ? (~bin_in + 1'b1) : bin_in;

   // Per-digit add-3 adjust; digits are independent, no carry between them
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ? (r_acc[4*k +: 4] + 4'd3)
                                                          : r_acc[4*k +: 4];
   end

   assign w_shift    = {w_adj[ACC_W-2:0], r_opnd[BIN_W-1]};
   assign w_ovf_next = r_ovf | w_adj[ACC_W-1];
   assign w_last     = (r_cnt == LAST_CNT);

   always_ff @(posedge clk or negedge clear_BAR) begin
      if (!clear_BAR) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start)  w_state_next = S_SHIFT;
         S_SHIFT: if (w_last) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign ready = (r_state == S_IDLE);
   assign busy  = (r_state == S_SHIFT);
   assign done  = (r_state == S_DONE);

   always_ff @(posedge clk or negedge clear_BAR) begin
      if (!clear_BAR) begin
         r_opnd   <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sign   <= 1'b0;
         r_ovf    <= 1'b0;
         bcd_out  <= '0;
         sign     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_opnd <= w_mag;
                  r_sign <= w_neg;
                  r_acc  <= '0;
                  r_cnt  <= '0;
                  r_ovf  <= 1'b0;
               end
            end
            S_SHIFT: begin
               r_acc  <= w_shift;
               r_opnd <= {r_opnd[BIN_W-2:0], 1'b0};
               r_ovf  <= w_ovf_next;
               r_cnt  <= r_cnt + 1'b1;
               // Visible result only changes on the final shift
               if (w_last) begin
                  bcd_out  <= w_shift;
                  sign     <= r_sign;
                  overflow <= w_ovf_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm.
- It is the generalised successor to the fixed 8-bit / 3-digit serial converter.
- Adds configurable input width and digit count, optional signed (two's-complement) input, a start/busy/done handshake, and an overflow flag.
- Sits between datapath results and display/print logic; one conversion in flight at a time.

Parameters:
- BIN_W, 8: binary input width in bits; legal range 2..32.
- DIGITS, 3: number of BCD digits produced; legal range 1..10.
- SIGNED, 0: 0 treats bin_in as unsigned; 1 treats it as two's complement, converts the magnitude and reports the sign separately.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- clear_BAR  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion; sampled only in IDLE.
- bin_in  in  BIN_W  operand; sampled on the edge that accepts start.
- ready  out  1  high in IDLE only.
- busy  out  1  high in SHIFT only.
- done  out  1  one-cycle pulse; bcd_out, sign and overflow are valid from this cycle onward.
- bcd_out  out  4*DIGITS  result; digit k occupies bits [4k+3:4k], digit 0 is the least significant.
- sign  out  1  1 when SIGNED=1 and the operand was negative; always 0 when SIGNED=0.
- overflow  out  1  1 when the magnitude needs more than DIGITS digits.

Behaviour:
- Reset (clear_BAR=0, any time, including mid-conversion):
  - State goes to IDLE immediately.
  - bcd_out=0, sign=0, overflow=0, done=0, busy=0, ready=1.
  - Internal shift register and counter are cleared.
  - Release takes effect on the next rising edge.
- States and transitions:
  - IDLE -> SHIFT on the edge where start=1.
  - SHIFT -> SHIFT while count < BIN_W.
  - SHIFT -> DONE on the edge performing shift number BIN_W.
  - DONE -> IDLE on the next edge.
- Load (IDLE, start=1):
  - The operand register takes mag(bin_in).
  - mag = bin_in when SIGNED=0, or when SIGNED=1 and bin_in[BIN_W-1]=0.
  - Otherwise mag = two's-complement negation, taken as an unsigned BIN_W-bit value, so -2^(BIN_W-1) gives 2^(BIN_W-1).
  - Sign register takes SIGNED & bin_in[BIN_W-1].
  - Accumulator, count and overflow register are cleared.
- Each SHIFT edge, in order:
  - (a) Every 4-bit accumulator digit >= 5 gets +3 (4-bit add, no carry between digits).
  - (b) The adjusted accumulator is shifted left 1 bit; the operand MSB enters digit-0 bit 0.
  - (c) The operand register shifts left 1 bit, filling with 0.
  - (d) If the bit shifted out of the top digit is 1, the overflow register is set (sticky until the next load).
  - (e) count increments.
- Latency:
  - The start-accepting edge is E0; shifts occur on edges E1..E_BIN_W.
  - done=1 for exactly the cycle after E_BIN_W; ready returns at E_BIN_W+1.
  - Throughput: one conversion per BIN_W+2 cycles.
- Output registers:
  - bcd_out, sign and overflow update only at E_BIN_W.
  - They hold that value through DONE, IDLE and the next conversion, until the following E_BIN_W or reset.
  - An in-progress conversion never disturbs the visible result.
- Boundary conditions:
  - start while busy or done: ignored; no restart, no queueing.
  - start held high continuously: a new conversion is accepted on each IDLE cycle.
  - bin_in changes after E0: no effect.
  - Zero operand: bcd_out=0, sign=0, overflow=0.
  - SIGNED=1 with a negative zero-magnitude operand is impossible; no special case.
  - When overflow=1, bcd_out holds the low DIGITS digits of the true result (truncated modulo 10^DIGITS).
  - No digit of bcd_out ever exceeds 9 when overflow=0.

Test Plan:
- Default parameters, bin_in=8'b10011110 (158), start pulse at E0:
  - busy high for 8 cycles; done pulse at cycle 9.
  - bcd_out=12'h158, overflow=0, sign=0.
- Default parameters, bin_in=0 then bin_in=255 back-to-back (start held high):
  - bcd_out=12'h000, then 12'h255.
  - The second done arrives exactly 10 cycles after the first.
- SIGNED=1, BIN_W=8, bin_in=8'h80 (-128):
  - sign=1, bcd_out=12'h128.
  - A follow-up with bin_in=8'hFF gives sign=1, bcd_out=12'h001.
- DIGITS=2, bin_in=200 -> overflow=1, bcd_out=8'h00.
- DIGITS=2, bin_in=99 -> overflow=0, bcd_out=8'h99.
- BIN_W=16, DIGITS=5, bin_in=65535:
  - done at cycle 17, bcd_out=20'h65535.
  - Also pulse start at cycle 5 of that conversion: no effect, result unchanged.
- Reset mid-conversion:
  - Start 158, drive clear_BAR=0 asynchronously after 4 shifts: all outputs 0 immediately, ready=1.
  - After release, convert 42: bcd_out=12'h042.
